// File: rtl/mmio_fifo_port_if.sv
// Bus-side and stream-side signals of mmio_fifo_port; the shared tristate data bus stays a module port.
interface mmio_fifo_port_if #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
);
  logic              rd;
  logic              wr;
  logic [AWIDTH-1:0] addr;
  logic              hit;
  logic [DWIDTH-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DWIDTH-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              ovf;
  logic              unf;

  modport slave (
    input  rd, wr, addr, tx_ready, rx_data, rx_valid,
    output hit, tx_data, tx_valid, rx_ready, ovf, unf
  );

  modport master (
    output rd, wr, addr, tx_ready, rx_data, rx_valid,
    input  hit, tx_data, tx_valid, rx_ready, ovf, unf
  );
endinterface

// File: rtl/mmio_fifo_port.sv
// MMIO window on the CPU bus: stores push a TX FIFO, loads pop an RX FIFO once per access, STAT reads flags.
// Define MMIO_LOOPBACK_EN to feed the TX head straight into RX and idle the external stream ports.
module mmio_fifo_port #(
  parameter int                AWIDTH    = 5,
  parameter int                DWIDTH    = 8,
  parameter int                DEPTH     = 4,
  parameter logic [AWIDTH-1:0] DATA_ADDR = 5'h1E,
  parameter logic [AWIDTH-1:0] STAT_ADDR = 5'h1F
) (
  input  logic              clk,
  input  logic              rst,
  mmio_fifo_port_if.slave   bus,
  inout  wire  [DWIDTH-1:0] data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DWIDTH-1:0] tx_mem [DEPTH];
  logic [DWIDTH-1:0] rx_mem [DEPTH];
  logic [PW-1:0]     tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0]     tx_cnt, rx_cnt;
  logic [DWIDTH-1:0] hold;
  logic              rd_hit_q, ovf, unf;

  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              wr_hit, rd_hit, st_hit, rd_first;
  logic              tx_push, tx_pop, rx_push, rx_pop;
  logic [DWIDTH-1:0] tx_head, rx_head, rx_in, rd_val, status, drv_val;

  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_empty = (rx_cnt == '0);
  assign tx_head  = tx_mem[tx_rp];
  assign rx_head  = rx_mem[rx_rp];

  assign wr_hit   = bus.wr && (bus.addr == DATA_ADDR);
  assign rd_hit   = bus.rd && (bus.addr == DATA_ADDR);
  assign st_hit   = bus.rd && (bus.addr == STAT_ADDR);
  assign bus.hit  = (bus.addr == DATA_ADDR) || (bus.addr == STAT_ADDR);

  // Only the first cycle of a multi-cycle load pops; later cycles replay hold.
  assign rd_first = rd_hit && !rd_hit_q;
  assign rd_val   = rx_empty ? '0 : rx_head;
  assign tx_push  = wr_hit && !tx_full;
  assign rx_pop   = rd_first && !rx_empty;

`ifdef MMIO_LOOPBACK_EN
  logic lb_xfer;
  assign lb_xfer      = !tx_empty && !rx_full;
  assign tx_pop       = lb_xfer;
  assign rx_push      = lb_xfer;
  assign rx_in        = tx_head;
  assign bus.tx_valid = 1'b0;
  assign bus.rx_ready = 1'b0;
`else
  assign tx_pop       = !tx_empty && bus.tx_ready;
  assign rx_push      = bus.rx_valid && !rx_full;
  assign rx_in        = bus.rx_data;
  assign bus.tx_valid = !tx_empty;
  assign bus.rx_ready = !rx_full;
`endif

  assign bus.tx_data = tx_head;
  assign bus.ovf     = ovf;
  assign bus.unf     = unf;

  always_comb begin
    status           = '0;
    status[DWIDTH-1] = ovf;
    status[DWIDTH-2] = unf;
    status[3:0]      = {tx_full, tx_empty, rx_full, rx_empty};
    if (st_hit)
      drv_val = status;
    else if (rd_first)
      drv_val = rd_val;
    else
      drv_val = hold;
  end

  assign data = ((rd_hit || st_hit) && !rst) ? drv_val : 'z;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_cnt   <= '0;
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_cnt   <= '0;
      hold     <= '0;
      rd_hit_q <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else begin
      rd_hit_q <= rd_hit;
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
      if (wr_hit && tx_full) ovf <= 1'b1;
      if (rd_first) begin
        hold <= rd_val;
        if (rx_empty) unf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= data;
    if (rx_push) rx_mem[rx_wp] <= rx_in;
  end

endmodule

// File: tb/tb_mmio_fifo_port.sv
// Randomized bench for mmio_fifo_port against a queue-based model of the two FIFOs and the read access.
module tb_mmio_fifo_port;

  localparam int         DEPTH = 4;
  localparam logic [4:0] DA    = 5'h1E;
  localparam logic [4:0] SA    = 5'h1F;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_drv = 1'b0;
  logic [7:0] cpu_dat = 8'h00;
  wire  [7:0] data;

  assign data = cpu_drv ? cpu_dat : 8'hzz;

  mmio_fifo_port_if #(.AWIDTH(5), .DWIDTH(8)) bus ();

  mmio_fifo_port #(.AWIDTH(5), .DWIDTH(8), .DEPTH(DEPTH), .DATA_ADDR(DA), .STAT_ADDR(SA)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .data (data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  bit         m_ovf, m_unf, m_acc;
  logic [7:0] m_hold;

  bit         k_trdy;
  bit         k_rvld;
  logic [7:0] k_rdat;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_status();
    return {m_ovf, m_unf, 2'b00,
            txq.size() == DEPTH, txq.size() == 0,
            rxq.size() == DEPTH, rxq.size() == 0};
  endfunction

  // One bus cycle: drive at negedge, check just after, advance the model at the posedge.
  task automatic cycle(input bit r, input bit c_rd, input bit c_wr, input logic [4:0] a, input logic [7:0] wd);
    logic [7:0] exp_d, first_v, obs_d;
    bit         dhit, shit;
    int         tn, rn;
    @(negedge clk);
    rst          = r;
    bus.rd       = c_rd;
    bus.wr       = c_wr;
    bus.addr     = a;
    cpu_drv      = c_wr;
    cpu_dat      = wd;
    bus.tx_ready = k_trdy;
    bus.rx_valid = k_rvld;
    bus.rx_data  = k_rdat;
    #1;
    dhit    = (a == DA);
    shit    = (a == SA);
    first_v = (rxq.size() == 0) ? 8'h00 : rxq[0];
    if (!r && c_rd && dhit)
      exp_d = m_acc ? m_hold : first_v;
    else if (!r && c_rd && shit)
      exp_d = m_status();
    else
      exp_d = c_wr ? wd : 8'h00;
    obs_d = data;
    if (obs_d === 8'hzz) obs_d = 8'h00;
    check("data", obs_d, exp_d);
    check("hit", {7'b0, bus.hit}, {7'b0, dhit || shit});
`ifdef MMIO_LOOPBACK_EN
    check("tx_valid", {7'b0, bus.tx_valid}, 8'h00);
    check("rx_ready", {7'b0, bus.rx_ready}, 8'h00);
`else
    check("tx_valid", {7'b0, bus.tx_valid}, {7'b0, txq.size() > 0});
    if (txq.size() > 0) check("tx_data", bus.tx_data, txq[0]);
    check("rx_ready", {7'b0, bus.rx_ready}, {7'b0, rxq.size() < DEPTH});
`endif
    check("ovf", {7'b0, bus.ovf}, {7'b0, m_ovf});
    check("unf", {7'b0, bus.unf}, {7'b0, m_unf});
    @(posedge clk);
    if (r) begin
      txq.delete();
      rxq.delete();
      m_ovf  = 0;
      m_unf  = 0;
      m_acc  = 0;
      m_hold = 8'h00;
    end else begin
      tn = txq.size();
      rn = rxq.size();
      if (c_rd && dhit && !m_acc) begin
        m_hold = first_v;
        if (rn == 0) m_unf = 1;
        else void'(rxq.pop_front());
      end
`ifdef MMIO_LOOPBACK_EN
      if (tn > 0 && rn < DEPTH) begin
        rxq.push_back(txq[0]);
        void'(txq.pop_front());
      end
`else
      if (k_trdy && tn > 0) void'(txq.pop_front());
      if (k_rvld && rn < DEPTH) rxq.push_back(k_rdat);
`endif
      if (c_wr && dhit) begin
        if (tn == DEPTH) m_ovf = 1;
        else txq.push_back(wd);
      end
      m_acc = c_rd && dhit;
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 5'h00, 8'h00);
  endtask

  task automatic wr_data(input logic [7:0] v);
    cycle(0, 0, 1, DA, v);
  endtask

  task automatic st_rd();
    cycle(0, 1, 0, SA, 8'h00);
  endtask

  task automatic rd_acc(input int n);
    for (int i = 0; i < n; i++) cycle(0, 1, 0, DA, 8'h00);
    idle();
  endtask

  task automatic do_rst();
    cycle(1, 0, 0, 5'h00, 8'h00);
  endtask

  initial begin
    bus.rd = 0; bus.wr = 0; bus.addr = 5'h00;
    bus.tx_ready = 0; bus.rx_valid = 0; bus.rx_data = 8'h00;
    k_trdy = 0; k_rvld = 0; k_rdat = 8'h00;
    m_ovf = 0; m_unf = 0; m_acc = 0; m_hold = 8'h00;
    repeat (2) @(posedge clk);

    // Reset state and release of the bus
    do_rst();
    do_rst();
    st_rd();
    idle();

    // TX fill past full, then drain in order
    wr_data(8'hA5);
    wr_data(8'hB1);
    wr_data(8'hB2);
    wr_data(8'hB3);
    wr_data(8'hB4);
    st_rd();
    k_trdy = 1;
    repeat (5) idle();
    k_trdy = 0;

    // RX: one pop per multi-cycle access, then underflow
    k_rvld = 1; k_rdat = 8'h3C; idle();
    k_rdat = 8'hC3; idle();
    k_rvld = 0;
    rd_acc(3);
    rd_acc(3);
    rd_acc(3);
    st_rd();

    // Full RX with CPU pop and source push in the same cycle
    do_rst();
    k_rvld = 1;
    for (int i = 0; i < DEPTH; i++) begin
      k_rdat = 8'h40 + 8'(i);
      idle();
    end
    k_rdat = 8'h77;
    rd_acc(2);
    k_rvld = 0;
    st_rd();
    for (int i = 0; i < DEPTH; i++) rd_acc(1);

    // Reset in the middle of a read access
    k_rvld = 1; k_rdat = 8'h5A; idle();
    k_rvld = 0;
    cycle(0, 1, 0, DA, 8'h00);
    cycle(0, 1, 0, DA, 8'h00);
    cycle(1, 1, 0, DA, 8'h00);
    cycle(0, 1, 0, DA, 8'h00);
    idle();
    st_rd();

    // Writes then reads (loops back through RX when that build option is set)
    do_rst();
    wr_data(8'h11);
    wr_data(8'h22);
    idle();
    idle();
    rd_acc(1);
    rd_acc(1);

    // Random traffic
    do_rst();
    for (int i = 0; i < 400; i++) begin
      k_trdy = 1'($urandom_range(0, 1));
      k_rvld = 1'($urandom_range(0, 1));
      k_rdat = 8'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2: wr_data(8'($urandom));
        3:       cycle(0, 0, 1, SA, 8'($urandom));
        4, 5:    rd_acc(int'($urandom_range(1, 3)));
        6:       st_rd();
        7:       cycle(0, 1, 0, 5'($urandom_range(0, 29)), 8'h00);
        8:       idle();
        default: if ($urandom_range(0, 9) == 0) do_rst(); else idle();
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
